// File: rtl/sdram_cpu_bridge_pkg.sv
// sdram_bridge_pkg: shared types and helpers for the CPU-to-SDRAM bridge.
package sdram_bridge_pkg;

    typedef enum logic [1:0] {SYNC, IDLE, RD_DRAIN, RD_WAIT} state_t;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } wr_entry_t;

    function automatic logic [1:0] ds_of(input logic a0);
        return a0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_cpu_bridge_if.sv
// cpu_bus_if / sdram_port_if: Z80-side byte bus and SDRAM toggle-handshake port.
interface cpu_bus_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [23:0] cpu_a;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_busy;
    modport master(output cpu_rd, cpu_wr, cpu_a, cpu_din, input cpu_dout, cpu_busy);
    modport slave(input cpu_rd, cpu_wr, cpu_a, cpu_din, output cpu_dout, cpu_busy);
endinterface

interface sdram_port_if;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_we;
    logic [22:0] sdram_a;
    logic [1:0]  sdram_ds;
    logic [15:0] sdram_d;
    logic [15:0] sdram_q;
    modport master(output sdram_req, sdram_we, sdram_a, sdram_ds, sdram_d, input sdram_ack, sdram_q);
    modport slave(input sdram_req, sdram_we, sdram_a, sdram_ds, sdram_d, output sdram_ack, sdram_q);
endinterface

// File: rtl/sdram_cpu_bridge_wr_fifo.sv
// sdram_wr_fifo: posted-write queue; occupancy carries one extra bit so full and empty differ.
module sdram_wr_fifo
    import sdram_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  wr_entry_t                     din,
    output wr_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    wr_entry_t     mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge: byte-wide CPU strobes to word SDRAM requests with posted writes and a one-word read cache.
module sdram_cpu_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    cpu_bus_if.slave     cpu,
    sdram_port_if.master sdram
);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t        state;
    state_t        state_n;
    logic          req_q = 1'b0;
    logic          busy_q;
    logic          busy_n;
    logic [7:0]    dout_q;
    logic          we_q;
    logic [22:0]   a_q;
    logic [1:0]    ds_q;
    logic [15:0]   d_q;
    logic          wr_inflight;
    logic          cache_v;
    logic [22:0]   cache_tag;
    logic [15:0]   cache_d;
    logic [22:0]   rd_a;
    logic          rd_b;
    logic          outstanding;
    logic          rd_ok;
    logic          wr_ok;
    logic          hit;
    logic          wr_done;
    logic          issue_wr;
    logic          issue_rd;
    logic          rd_done;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW:0]   lvl_n;
    wr_entry_t     entry;
    wr_entry_t     head;

    sdram_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_ok),
        .pop   (wr_done),
        .din   (entry),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        outstanding = req_q != sdram.sdram_ack;
        wr_ok       = cpu.cpu_wr && !busy_q;
        rd_ok       = cpu.cpu_rd && !cpu.cpu_wr && !busy_q;
        hit         = cache_v && cache_tag == cpu.cpu_a[23:1];
        entry       = '{a: cpu.cpu_a[23:1], ds: ds_of(cpu.cpu_a[0]), d: {2{cpu.cpu_din}}};
        wr_done     = wr_inflight && !outstanding;
        issue_wr    = (state == IDLE || state == RD_DRAIN) && !empty && !outstanding && !wr_inflight;
        issue_rd    = state == RD_DRAIN && empty && !outstanding && !wr_inflight;
        rd_done     = state == RD_WAIT && !outstanding;
        lvl_n       = count + (AW+1)'(wr_ok) - (AW+1)'(wr_done);
        state_n     = (state == SYNC)     ? (outstanding ? SYNC : IDLE) :
                      (state == IDLE)     ? ((rd_ok && !hit) ? RD_DRAIN : IDLE) :
                      (state == RD_DRAIN) ? (issue_rd ? RD_WAIT : RD_DRAIN) :
                                            (outstanding ? RD_WAIT : IDLE);
        busy_n      = lvl_n == (AW+1)'(FIFO_DEPTH) || state_n != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            busy_q      <= 1'b1;
            dout_q      <= '0;
            we_q        <= 1'b0;
            a_q         <= '0;
            ds_q        <= '0;
            d_q         <= '0;
            wr_inflight <= 1'b0;
            cache_v     <= 1'b0;
            cache_tag   <= '0;
            cache_d     <= '0;
            rd_a        <= '0;
            rd_b        <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= busy_n;
            if (issue_wr) begin
                we_q        <= 1'b1;
                a_q         <= head.a;
                ds_q        <= head.ds;
                d_q         <= head.d;
                wr_inflight <= 1'b1;
            end else if (wr_done) begin
                wr_inflight <= 1'b0;
            end
            if (issue_rd) begin
                we_q <= 1'b0;
                a_q  <= rd_a;
                ds_q <= 2'b11;
            end
            // Write-through keeps the cached word coherent with the posted write.
            if (wr_ok && cache_v && cache_tag == cpu.cpu_a[23:1]) begin
                if (cpu.cpu_a[0]) cache_d[15:8] <= cpu.cpu_din;
                else cache_d[7:0] <= cpu.cpu_din;
            end
            if (rd_ok && hit) dout_q <= cpu.cpu_a[0] ? cache_d[15:8] : cache_d[7:0];
            if (rd_ok && !hit) begin
                rd_a <= cpu.cpu_a[23:1];
                rd_b <= cpu.cpu_a[0];
            end
            if (rd_done) begin
                cache_v   <= 1'b1;
                cache_tag <= rd_a;
                cache_d   <= sdram.sdram_q;
                dout_q    <= rd_b ? sdram.sdram_q[15:8] : sdram.sdram_q[7:0];
            end
        end
    end

    // The toggle survives reset so an in-flight request still pairs with its ack.
    always_ff @(posedge clk) begin
        if (!reset && (issue_wr || issue_rd)) req_q <= !req_q;
    end

    assign sdram.sdram_req = req_q;
    assign sdram.sdram_we  = we_q;
    assign sdram.sdram_a   = a_q;
    assign sdram.sdram_ds  = ds_q;
    assign sdram.sdram_d   = d_q;
    assign cpu.cpu_busy    = busy_q;
    assign cpu.cpu_dout    = dout_q;

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// tb_sdram_cpu_bridge: directed steps with a request scoreboard checked by a modelled SDRAM port.
module tb_sdram_cpu_bridge;

    typedef struct {
        logic        we;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    req_t        exp_q[$];
    logic        ack_r = 1'b0;
    logic [15:0] q_r = 16'h0;
    logic [15:0] q_val = 16'h0;
    int          ack_delay = 2;
    int          n_req = 0;
    int          cnt = 0;
    logic        pending = 1'b0;
    logic        pend_req = 1'b0;

    cpu_bus_if    cpu();
    sdram_port_if bus();

    assign bus.sdram_ack = ack_r;
    assign bus.sdram_q   = q_r;

    sdram_cpu_bridge #(.FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (rst),
        .cpu   (cpu),
        .sdram (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_req(input logic we, input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
        req_t e;
        e.we = we; e.a = a; e.ds = ds; e.d = d;
        exp_q.push_back(e);
    endtask

    // Modelled SDRAM port: one request at a time, acked after ack_delay cycles.
    always @(negedge clk) begin
        req_t e;
        if (pending) begin
            check("req_hold", bus.sdram_req, pend_req);
            if (cnt > 0) cnt--;
            else begin
                q_r     = q_val;
                ack_r   = pend_req;
                pending = 1'b0;
            end
        end else if (bus.sdram_req !== ack_r) begin
            pending  = 1'b1;
            pend_req = bus.sdram_req;
            cnt      = ack_delay;
            n_req++;
            check("req_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("req_we", bus.sdram_we, e.we);
                check("req_a", bus.sdram_a, e.a);
                check("req_ds", bus.sdram_ds, e.ds);
                if (e.we) check("req_d", bus.sdram_d, e.d);
            end
        end
    end

    task automatic strobe(input logic rd, input logic wr, input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu.cpu_rd = rd; cpu.cpu_wr = wr; cpu.cpu_a = a; cpu.cpu_din = d;
        @(negedge clk);
        cpu.cpu_rd = 1'b0; cpu.cpu_wr = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cpu.cpu_busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, cpu.cpu_busy, 0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || pending || cpu.cpu_busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(tag, exp_q.size() == 0 && !pending, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        cpu.cpu_rd = 1'b0; cpu.cpu_wr = 1'b0; cpu.cpu_a = '0; cpu.cpu_din = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", cpu.cpu_busy, 1);
        check("rst_dout", cpu.cpu_dout, 8'h00);
        check("rst_we", bus.sdram_we, 0);
        check("rst_ds", bus.sdram_ds, 2'b00);
        check("rst_a", bus.sdram_a, 23'h0);
        check("rst_d", bus.sdram_d, 16'h0);
        rst = 1'b0;
        wait_ready("sync_exit");

        // Read miss then a hit on the other byte of the same word.
        q_val = 16'hBEEF;
        expect_req(1'b0, 23'h000080, 2'b11, 16'h0);
        strobe(1'b1, 1'b0, 24'h000101, 8'h00);
        check("miss_busy", cpu.cpu_busy, 1);
        wait_ready("miss_ready");
        check("miss_dout", cpu.cpu_dout, 8'hBE);
        check("miss_nreq", n_req, 1);
        strobe(1'b1, 1'b0, 24'h000100, 8'h00);
        check("hit_busy", cpu.cpu_busy, 0);
        check("hit_dout", cpu.cpu_dout, 8'hEF);
        check("hit_nreq", n_req, 1);

        // Two posted writes fill the FIFO; a strobe while busy is dropped.
        ack_delay = 10;
        expect_req(1'b1, 23'h000008, 2'b01, 16'h5555);
        expect_req(1'b1, 23'h000008, 2'b10, 16'hAAAA);
        @(negedge clk);
        cpu.cpu_wr = 1'b1; cpu.cpu_a = 24'h000010; cpu.cpu_din = 8'h55;
        @(negedge clk);
        check("wr1_busy", cpu.cpu_busy, 0);
        cpu.cpu_a = 24'h000011; cpu.cpu_din = 8'hAA;
        @(negedge clk);
        cpu.cpu_wr = 1'b0;
        check("full_busy", cpu.cpu_busy, 1);
        strobe(1'b0, 1'b1, 24'h000020, 8'hEE);
        wait_drain("wr_drain");
        check("wr_nreq", n_req, 3);

        // Write-through into the cached word, then a hit with no read request.
        ack_delay = 2;
        expect_req(1'b1, 23'h000080, 2'b01, 16'h1212);
        strobe(1'b0, 1'b1, 24'h000100, 8'h12);
        strobe(1'b1, 1'b0, 24'h000100, 8'h00);
        check("wt_dout", cpu.cpu_dout, 8'h12);
        wait_drain("wt_drain");
        check("wt_nreq", n_req, 4);

        // A read miss must wait behind an un-acked posted write.
        ack_delay = 8;
        q_val = 16'h3456;
        expect_req(1'b1, 23'h000100, 2'b01, 16'h7777);
        expect_req(1'b0, 23'h000180, 2'b11, 16'h0);
        strobe(1'b0, 1'b1, 24'h000200, 8'h77);
        strobe(1'b1, 1'b0, 24'h000300, 8'h00);
        wait_ready("order_ready");
        check("order_dout", cpu.cpu_dout, 8'h56);
        check("order_nreq", n_req, 6);

        // Reset during an outstanding read: SYNC holds busy until the ack and drops the data.
        ack_delay = 5;
        q_val = 16'h9999;
        expect_req(1'b0, 23'h000200, 2'b11, 16'h0);
        strobe(1'b1, 1'b0, 24'h000400, 8'h00);
        n = 0;
        while (!pending && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rr_pending", pending, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_busy0", cpu.cpu_busy, 1);
        @(negedge clk);
        check("rr_busy1", cpu.cpu_busy, 1);
        wait_ready("rr_ready");
        check("rr_acked", pending, 0);
        check("rr_dout", cpu.cpu_dout, 8'h00);
        q_val = 16'h1234;
        expect_req(1'b0, 23'h000200, 2'b11, 16'h0);
        strobe(1'b1, 1'b0, 24'h000400, 8'h00);
        wait_ready("rr2_ready");
        check("rr2_dout", cpu.cpu_dout, 8'h34);
        check("rr2_nreq", n_req, 8);

        // Simultaneous read and write: only the write happens.
        ack_delay = 2;
        expect_req(1'b1, 23'h000200, 2'b10, 16'hABAB);
        strobe(1'b1, 1'b1, 24'h000401, 8'hAB);
        check("rw_dout", cpu.cpu_dout, 8'h34);
        strobe(1'b1, 1'b0, 24'h000401, 8'h00);
        check("rw_hit_dout", cpu.cpu_dout, 8'hAB);
        wait_drain("rw_drain");
        check("rw_nreq", n_req, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
